// File: rtl/spgd_update_if.sv
// Bus bundle for spgd_update: perturbation/gain/metric inputs and control/status outputs.
interface spgd_update_if #(
  parameter int unsigned FP_WIDTH = 32
);
  logic                run;
  logic [FP_WIDTH-1:0] PERT_A;
  logic [FP_WIDTH-1:0] PERT_B;
  logic [FP_WIDTH-1:0] GAIN;
  logic [FP_WIDTH-1:0] metric_in;
  logic                metric_valid;
  logic [FP_WIDTH-1:0] CTRL_A;
  logic [FP_WIDTH-1:0] CTRL_B;
  logic                meas_req;
  logic                busy;
  logic                iter_done;
  logic [15:0]         iter_count;

  modport master (
    output run, PERT_A, PERT_B, GAIN, metric_in, metric_valid,
    input  CTRL_A, CTRL_B, meas_req, busy, iter_done, iter_count
  );

  modport slave (
    input  run, PERT_A, PERT_B, GAIN, metric_in, metric_valid,
    output CTRL_A, CTRL_B, meas_req, busy, iter_done, iter_count
  );
endinterface

// File: rtl/spgd_update.sv
// Two-sided SPGD iteration engine: applies u+d and u-d, measures J+/J-, then
// updates u by GAIN*(J+ - J-)*d in signed fixed point with saturation.
module spgd_update #(
  parameter int unsigned         FP_WIDTH      = 32,
  parameter int unsigned         FRAC_BITS     = 16,
  parameter int unsigned         SETTLE_CYCLES = 8,
  parameter logic [FP_WIDTH-1:0] CTRL_MIN      = 32'hFFF0_0000,
  parameter logic [FP_WIDTH-1:0] CTRL_MAX      = 32'h0010_0000
) (
  input logic         clk,
  input logic         rst,
  spgd_update_if.slave bus
);

  // Every intermediate lives at this width so products and sums never overflow.
  localparam int unsigned WW   = 2 * FP_WIDTH + 2;
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  localparam logic signed [WW-1:0] FpMaxW =
      {{(WW-FP_WIDTH+1){1'b0}}, {(FP_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] FpMinW =
      {{(WW-FP_WIDTH+1){1'b1}}, {(FP_WIDTH-1){1'b0}}};
  localparam logic signed [WW-1:0] CtrlMinW =
      {{(WW-FP_WIDTH){CTRL_MIN[FP_WIDTH-1]}}, CTRL_MIN};
  localparam logic signed [WW-1:0] CtrlMaxW =
      {{(WW-FP_WIDTH){CTRL_MAX[FP_WIDTH-1]}}, CTRL_MAX};
  localparam logic [CntW-1:0] SettleReload = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StPlus, StWaitP, StMinus, StWaitM, StCalc1, StCalc2, StUpdate
  } state_e;

  function automatic logic signed [WW-1:0] ext(input logic [FP_WIDTH-1:0] x);
    return {{(WW-FP_WIDTH){x[FP_WIDTH-1]}}, x};
  endfunction

  function automatic logic [FP_WIDTH-1:0] sat(input logic signed [WW-1:0] x,
                                              input logic signed [WW-1:0] lo,
                                              input logic signed [WW-1:0] hi);
    logic signed [WW-1:0] r;
    r = x;
    if (x < lo) r = lo;
    if (x > hi) r = hi;
    return r[FP_WIDTH-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                meas_req_q, meas_req_d;

  logic [FP_WIDTH-1:0] u_a_q, u_b_q, ctrl_a_q, ctrl_b_q;
  logic [FP_WIDTH-1:0] d_a_q, d_b_q, gain_q, jp_q, jm_q;
  logic [FP_WIDTH-1:0] g_q, delta_a_q, delta_b_q;
  logic [15:0]         iter_count_q;

  logic signed [WW-1:0] diff, prod_g, prod_a, prod_b;
  logic [FP_WIDTH-1:0]  plus_a, plus_b, minus_a, minus_b, upd_a, upd_b;
  logic [FP_WIDTH-1:0]  g_next, delta_a_next, delta_b_next;

  always_comb begin
    plus_a       = sat(ext(u_a_q) + ext(bus.PERT_A), CtrlMinW, CtrlMaxW);
    plus_b       = sat(ext(u_b_q) + ext(bus.PERT_B), CtrlMinW, CtrlMaxW);
    minus_a      = sat(ext(u_a_q) - ext(d_a_q), CtrlMinW, CtrlMaxW);
    minus_b      = sat(ext(u_b_q) - ext(d_b_q), CtrlMinW, CtrlMaxW);
    diff         = ext(jp_q) - ext(jm_q);
    prod_g       = diff * ext(gain_q);
    g_next       = sat(prod_g >>> FRAC_BITS, FpMinW, FpMaxW);
    prod_a       = ext(g_q) * ext(d_a_q);
    prod_b       = ext(g_q) * ext(d_b_q);
    delta_a_next = sat(prod_a >>> FRAC_BITS, FpMinW, FpMaxW);
    delta_b_next = sat(prod_b >>> FRAC_BITS, FpMinW, FpMaxW);
    upd_a        = sat(ext(u_a_q) + ext(delta_a_q), CtrlMinW, CtrlMaxW);
    upd_b        = sat(ext(u_b_q) + ext(delta_b_q), CtrlMinW, CtrlMaxW);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    meas_req_d = 1'b0;
    case (state_q)
      StIdle:  if (bus.run) state_d = StLoad;
      StLoad: begin
        state_d = StPlus;
        cnt_d   = SettleReload;
      end
      StPlus, StMinus: begin
        if (cnt_q == '0) begin
          state_d    = (state_q == StPlus) ? StWaitP : StWaitM;
          meas_req_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitP: begin
        if (bus.metric_valid) begin
          state_d = StMinus;
          cnt_d   = SettleReload;
        end
      end
      StWaitM:  if (bus.metric_valid) state_d = StCalc1;
      StCalc1:  state_d = StCalc2;
      StCalc2:  state_d = StUpdate;
      StUpdate: state_d = bus.run ? StLoad : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      meas_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      meas_req_q <= meas_req_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_a_q        <= '0;
      u_b_q        <= '0;
      ctrl_a_q     <= '0;
      ctrl_b_q     <= '0;
      d_a_q        <= '0;
      d_b_q        <= '0;
      gain_q       <= '0;
      jp_q         <= '0;
      jm_q         <= '0;
      g_q          <= '0;
      delta_a_q    <= '0;
      delta_b_q    <= '0;
      iter_count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          ctrl_a_q <= u_a_q;
          ctrl_b_q <= u_b_q;
        end
        StLoad: begin
          d_a_q    <= bus.PERT_A;
          d_b_q    <= bus.PERT_B;
          gain_q   <= bus.GAIN;
          ctrl_a_q <= plus_a;
          ctrl_b_q <= plus_b;
        end
        StWaitP: begin
          if (bus.metric_valid) begin
            jp_q     <= bus.metric_in;
            ctrl_a_q <= minus_a;
            ctrl_b_q <= minus_b;
          end
        end
        StWaitM:  if (bus.metric_valid) jm_q <= bus.metric_in;
        StCalc1:  g_q <= g_next;
        StCalc2: begin
          delta_a_q <= delta_a_next;
          delta_b_q <= delta_b_next;
        end
        StUpdate: begin
          u_a_q        <= upd_a;
          u_b_q        <= upd_b;
          ctrl_a_q     <= upd_a;
          ctrl_b_q     <= upd_b;
          iter_count_q <= iter_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.CTRL_A     = ctrl_a_q;
  assign bus.CTRL_B     = ctrl_b_q;
  assign bus.meas_req   = meas_req_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.iter_done  = (state_q == StUpdate);
  assign bus.iter_count = iter_count_q;

endmodule

// File: tb/tb_spgd_update.sv
// Self-checking bench for spgd_update: directed and randomized iterations scored
// against a fixed-point reference model of the SPGD update rule.
module tb_spgd_update;

  localparam int Settle  = 8;
  localparam int IterLen = 1 + 2 * (Settle + 1) + 3;

  typedef logic signed [127:0] big_t;
  localparam big_t CMin  = -128'sd1048576;
  localparam big_t CMax  = 128'sd1048576;
  localparam big_t FpMin = -128'sd2147483648;
  localparam big_t FpMax = 128'sd2147483647;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spgd_update_if #(.FP_WIDTH(32)) bus ();

  spgd_update #(
    .FP_WIDTH     (32),
    .FRAC_BITS    (16),
    .SETTLE_CYCLES(Settle),
    .CTRL_MIN     (32'hFFF0_0000),
    .CTRL_MAX     (32'h0010_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  big_t        exp_u_a, exp_u_b;
  big_t        exp_plus_a, exp_plus_b, exp_minus_a, exp_minus_b;
  logic [15:0] exp_count;

  // Observations from the most recent iteration.
  logic [31:0] obs_start_a, obs_start_b, obs_plus_a, obs_plus_b, obs_minus_a, obs_minus_b;
  int          obs_len, obs_meas, obs_done;
  bit          obs_timeout, obs_hold_ok, obs_load_busy;

  function automatic big_t sx(input logic [31:0] v);
    return big_t'($signed(v));
  endfunction

  function automatic big_t clampv(input big_t x, input big_t lo, input big_t hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Floor division by 2^16, i.e. a fixed-point rescale rounding toward -inf.
  function automatic big_t fdiv(input big_t x);
    big_t q;
    q = x / 65536;
    if (x < 0 && q * 65536 != x) q = q - 1;
    return q;
  endfunction

  task automatic model_iter(input logic [31:0] pa, pb, gn, jp, jm);
    big_t g;
    exp_plus_a  = clampv(exp_u_a + sx(pa), CMin, CMax);
    exp_plus_b  = clampv(exp_u_b + sx(pb), CMin, CMax);
    exp_minus_a = clampv(exp_u_a - sx(pa), CMin, CMax);
    exp_minus_b = clampv(exp_u_b - sx(pb), CMin, CMax);
    g = clampv(fdiv((sx(jp) - sx(jm)) * sx(gn)), FpMin, FpMax);
    exp_u_a = clampv(exp_u_a + clampv(fdiv(g * sx(pa)), FpMin, FpMax), CMin, CMax);
    exp_u_b = clampv(exp_u_b + clampv(fdiv(g * sx(pb)), FpMin, FpMax), CMin, CMax);
    exp_count = exp_count + 16'd1;
  endtask

  function automatic logic [31:0] lo32(input big_t x);
    return x[31:0];
  endfunction

  // Drives one iteration starting at a negedge where the DUT is idle or in its update
  // cycle; returns at the negedge of the update cycle. drop_mode: 0 keep run,
  // 1 drop at the first measurement request, 2 drop on entering the minus phase.
  task automatic iterate(input logic [31:0] pa, pb, gn, jp, jm, input int dly_p, dly_m,
                         input bit spur, input bit scram, input int drop_mode);
    int phase, wait_cnt, cyc;
    bit cap_minus, fin;
    logic [31:0] hold_a, hold_b;
    obs_meas = 0; obs_done = 0; obs_len = 0; obs_timeout = 0; obs_hold_ok = 1;
    phase = 0; wait_cnt = 0; cap_minus = 0; fin = 0; hold_a = '0; hold_b = '0;
    bus.run = 1'b1;
    bus.PERT_A = scram ? $urandom : pa;
    bus.PERT_B = scram ? $urandom : pb;
    bus.GAIN   = scram ? $urandom : gn;
    @(negedge clk);
    obs_load_busy = bus.busy;
    obs_start_a = bus.CTRL_A;
    obs_start_b = bus.CTRL_B;
    bus.PERT_A = pa; bus.PERT_B = pb; bus.GAIN = gn;
    @(negedge clk);
    cyc = 2;
    obs_plus_a = bus.CTRL_A;
    obs_plus_b = bus.CTRL_B;
    while (!fin) begin
      if (scram) begin
        bus.PERT_A = $urandom; bus.PERT_B = $urandom; bus.GAIN = $urandom;
      end
      bus.metric_valid = 1'b0;
      if (bus.meas_req) obs_meas++;
      if (bus.iter_done) obs_done++;
      if (cap_minus) begin
        cap_minus = 0;
        obs_minus_a = bus.CTRL_A;
        obs_minus_b = bus.CTRL_B;
        if (drop_mode == 2) bus.run = 1'b0;
      end
      if ((phase == 0 || phase == 2) && bus.meas_req) begin
        phase++;
        wait_cnt = 0;
        hold_a = bus.CTRL_A;
        hold_b = bus.CTRL_B;
        if (drop_mode == 1) bus.run = 1'b0;
      end
      if (phase == 1 || phase == 3) begin
        if (bus.CTRL_A !== hold_a || bus.CTRL_B !== hold_b || !bus.busy) obs_hold_ok = 0;
        if (wait_cnt == ((phase == 1) ? dly_p : dly_m)) begin
          bus.metric_valid = 1'b1;
          bus.metric_in = (phase == 1) ? jp : jm;
          if (phase == 1) cap_minus = 1;
          phase++;
        end else begin
          wait_cnt++;
        end
      end else if (phase == 4 && bus.iter_done) begin
        obs_len = cyc;
        fin = 1;
      end else if (spur) begin
        bus.metric_valid = 1'($urandom_range(0, 1));
        bus.metric_in = $urandom;
      end
      if (!fin) begin
        if (cyc >= 600) begin
          obs_timeout = 1;
          fin = 1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    bus.metric_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.metric_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_u_a = 0; exp_u_b = 0; exp_count = 0;
  endtask

  task automatic test_reset();
    int pulses;
    bus.run = 1'b0; bus.metric_valid = 1'b0; bus.metric_in = '0;
    bus.PERT_A = 32'h1234_5678; bus.PERT_B = 32'h8765_4321; bus.GAIN = 32'h0001_0000;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.CTRL_A !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_held: busy=%b ctrl_a=%h required busy=0 ctrl_a=0", bus.busy, bus.CTRL_A);
    end
    rst = 1'b1;
    exp_u_a = 0; exp_u_b = 0; exp_count = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.meas_req) pulses++;
    end
    tests_run++;
    if (bus.CTRL_A !== 32'h0 || bus.CTRL_B !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %h/%h required 0/0", bus.CTRL_A, bus.CTRL_B);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b required 0", bus.busy);
    end
    tests_run++;
    if (bus.iter_count !== 16'h0) begin
      tests_failed++; $display("FAIL reset_count: got %0d required 0", bus.iter_count);
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++; $display("FAIL reset_meas_req: got %0d pulses required 0", pulses);
    end
  endtask

  task automatic check_iter(input string nm, input int len_req);
    tests_run++;
    if (obs_timeout) begin
      tests_failed++; $display("FAIL %s_timeout: iteration did not complete", nm);
    end
    tests_run++;
    if (obs_plus_a !== lo32(exp_plus_a) || obs_plus_b !== lo32(exp_plus_b)) begin
      tests_failed++;
      $display("FAIL %s_plus: got %h/%h required %h/%h", nm, obs_plus_a, obs_plus_b,
               lo32(exp_plus_a), lo32(exp_plus_b));
    end
    tests_run++;
    if (obs_minus_a !== lo32(exp_minus_a) || obs_minus_b !== lo32(exp_minus_b)) begin
      tests_failed++;
      $display("FAIL %s_minus: got %h/%h required %h/%h", nm, obs_minus_a, obs_minus_b,
               lo32(exp_minus_a), lo32(exp_minus_b));
    end
    tests_run++;
    if (obs_meas !== 2 || obs_done !== 1 || !obs_hold_ok || !obs_load_busy) begin
      tests_failed++;
      $display("FAIL %s_handshake: meas=%0d done=%0d hold=%b load_busy=%b required 2/1/1/1",
               nm, obs_meas, obs_done, obs_hold_ok, obs_load_busy);
    end
    if (len_req > 0) begin
      tests_run++;
      if (obs_len !== len_req) begin
        tests_failed++; $display("FAIL %s_len: got %0d required %0d", nm, obs_len, len_req);
      end
    end
  endtask

  task automatic check_final(input string nm);
    tests_run++;
    if (bus.CTRL_A !== lo32(exp_u_a) || bus.CTRL_B !== lo32(exp_u_b)) begin
      tests_failed++;
      $display("FAIL %s_final: got %h/%h required %h/%h", nm, bus.CTRL_A, bus.CTRL_B,
               lo32(exp_u_a), lo32(exp_u_b));
    end
    tests_run++;
    if (bus.iter_count !== exp_count) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d required %0d", nm, bus.iter_count, exp_count);
    end
  endtask

  task automatic test_basic();
    iterate(32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000,
            0, 0, 0, 0, 1);
    model_iter(32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000);
    check_iter("basic", IterLen);
    tests_run++;
    if (obs_plus_a !== 32'h0000_8000 || obs_plus_b !== 32'hFFFF_0000 ||
        obs_minus_a !== 32'hFFFF_8000 || obs_minus_b !== 32'h0001_0000) begin
      tests_failed++;
      $display("FAIL basic_applied: plus %h/%h minus %h/%h", obs_plus_a, obs_plus_b,
               obs_minus_a, obs_minus_b);
    end
    @(negedge clk);
    tests_run++;
    if (bus.CTRL_A !== 32'h0001_0000 || bus.CTRL_B !== 32'hFFFE_0000 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: got %h/%h busy=%b required 00010000/fffe0000 busy=0",
               bus.CTRL_A, bus.CTRL_B, bus.busy);
    end
    check_final("basic");
  endtask

  task automatic test_saturation();
    iterate(32'h0001_0000, 32'hFFFF_0000, 32'h0100_0000, 32'h0002_0000, 32'h0, 0, 0, 0, 0, 1);
    model_iter(32'h0001_0000, 32'hFFFF_0000, 32'h0100_0000, 32'h0002_0000, 32'h0);
    check_iter("sat1", IterLen);
    @(negedge clk);
    check_final("sat1");
    tests_run++;
    if (bus.CTRL_A !== 32'h0010_0000 || bus.CTRL_B !== 32'hFFF0_0000) begin
      tests_failed++;
      $display("FAIL sat1_bound: got %h/%h required 00100000/fff00000", bus.CTRL_A, bus.CTRL_B);
    end
    iterate(32'h0008_0000, 32'h0008_0000, 32'h0100_0000, 32'h4000_0000, 32'hC000_0000,
            0, 0, 0, 0, 1);
    model_iter(32'h0008_0000, 32'h0008_0000, 32'h0100_0000, 32'h4000_0000, 32'hC000_0000);
    check_iter("sat2", IterLen);
    tests_run++;
    if (obs_plus_a !== 32'h0010_0000 || obs_minus_b !== 32'hFFF0_0000) begin
      tests_failed++;
      $display("FAIL sat2_delta_clamp: got %h/%h required 00100000/fff00000",
               obs_plus_a, obs_minus_b);
    end
    @(negedge clk);
    check_final("sat2");
  endtask

  task automatic test_handshake();
    do_reset();
    iterate(32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000,
            0, 0, 1, 0, 1);
    model_iter(32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000);
    check_iter("spurious", IterLen);
    @(negedge clk);
    check_final("spurious");
    tests_run++;
    if (bus.CTRL_A !== 32'h0001_0000 || bus.CTRL_B !== 32'hFFFE_0000) begin
      tests_failed++;
      $display("FAIL spurious_result: got %h/%h required 00010000/fffe0000",
               bus.CTRL_A, bus.CTRL_B);
    end
    iterate(32'h0000_4000, 32'h0000_2000, 32'h0000_8000, 32'h0000_1000, 32'h0005_0000,
            50, 7, 0, 0, 1);
    model_iter(32'h0000_4000, 32'h0000_2000, 32'h0000_8000, 32'h0000_1000, 32'h0005_0000);
    check_iter("delay", IterLen + 57);
    @(negedge clk);
    check_final("delay");
  endtask

  task automatic test_prng_decoupling();
    logic [31:0] pa, pb, gn, jp, jm;
    for (int i = 0; i < 4; i++) begin
      pa = $urandom_range(0, 32'h0006_0000) - 32'h0003_0000;
      pb = $urandom;
      gn = $urandom_range(0, 32'h0004_0000);
      jp = $urandom;
      jm = $urandom_range(0, 32'h0010_0000);
      iterate(pa, pb, gn, jp, jm, $urandom_range(0, 4), $urandom_range(0, 4), 1, 1, 1);
      model_iter(pa, pb, gn, jp, jm);
      check_iter("prng", 0);
      @(negedge clk);
      check_final("prng");
    end
  endtask

  task automatic test_back_to_back();
    iterate(32'h0000_2000, 32'hFFFF_E000, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000,
            0, 0, 0, 0, 0);
    model_iter(32'h0000_2000, 32'hFFFF_E000, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000);
    check_iter("b2b1", IterLen);
    iterate(32'h0001_0000, 32'h0000_4000, 32'h0000_4000, 32'h0002_0000, 32'h0, 0, 0, 0, 0, 2);
    tests_run++;
    if (obs_start_a !== lo32(exp_u_a) || obs_start_b !== lo32(exp_u_b)) begin
      tests_failed++;
      $display("FAIL b2b_chain: got %h/%h required %h/%h", obs_start_a, obs_start_b,
               lo32(exp_u_a), lo32(exp_u_b));
    end
    model_iter(32'h0001_0000, 32'h0000_4000, 32'h0000_4000, 32'h0002_0000, 32'h0);
    check_iter("b2b2", IterLen);
    @(negedge clk);
    check_final("run_drop");
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL run_drop_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int reqs, cyc;
    bus.run = 1'b1; bus.PERT_A = 32'h0000_8000; bus.PERT_B = 32'h0000_8000;
    bus.GAIN = 32'h0001_0000;
    reqs = 0; cyc = 0;
    while (reqs < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.metric_valid = 1'b0;
      if (bus.meas_req) begin
        reqs++;
        bus.run = 1'b0;
        if (reqs == 1) begin
          bus.metric_valid = 1'b1; bus.metric_in = 32'h0004_0000;
        end
      end
    end
    tests_run++;
    if (reqs != 2) begin
      tests_failed++; $display("FAIL rstmid_reach: got %0d meas_req required 2", reqs);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (bus.CTRL_A !== 32'h0 || bus.CTRL_B !== 32'h0 || bus.busy !== 1'b0 ||
        bus.meas_req !== 1'b0 || bus.iter_done !== 1'b0 || bus.iter_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL rstmid_async: ctrl %h/%h busy=%b req=%b done=%b cnt=%0d required all 0",
               bus.CTRL_A, bus.CTRL_B, bus.busy, bus.meas_req, bus.iter_done, bus.iter_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_u_a = 0; exp_u_b = 0; exp_count = 0;
    @(negedge clk);
    iterate(32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000,
            0, 0, 0, 0, 1);
    model_iter(32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000);
    check_iter("rstmid_after", IterLen);
    @(negedge clk);
    check_final("rstmid_after");
  endtask

  initial begin
    bus.run = 1'b0; bus.metric_valid = 1'b0; bus.metric_in = '0;
    bus.PERT_A = '0; bus.PERT_B = '0; bus.GAIN = '0;
    exp_u_a = 0; exp_u_b = 0; exp_count = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_handshake();
    test_prng_decoupling();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
